multicycle_control: RTL

Control unit for the multicycle ARM datapath, built on the single-cycle instruction decoder. It decodes Op/Funct/Rd/Cond, sequences each instruction through a Moore FSM and holds the NZCV flag register with full ARM condition evaluation. It also drives every datapath select and write enable. It sits between the instruction register and the shared-memory multicycle datapath. It adds EOR/MOV, byte memory access and conditional execution.

---
 rtl/arm_mc_pkg.sv | 62 ++++++
 rtl/cond_logic.sv | 70 +++++++
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } statetype_t;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Data-processing opcodes carried in Funct[4:1]
    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_EOR = 4'b0001;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;
    localparam logic [3:0] DP_MOV = 4'b1101;

    // Instruction class in Op
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Arithmetic opcodes are the only ones that produce meaningful C and V
    function automatic logic dp_is_arith(input logic [3:0] cmd);
        return (cmd == DP_ADD) | (cmd == DP_SUB) | (cmd == DP_CMP);
    endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register with split NZ/CV write enables and ARM condition evaluator.
module cond_logic
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_s, z_s, c_s, v_s, ge_s;

    // Merge freshly computed NZ and/or CV into the held flags
    always_comb begin
        flags_d = flags_q;
        if (FlagWrite[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (FlagWrite[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
    end

    // Flag register, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {n_s, z_s, c_s, v_s} = flags_q;
    assign ge_s                 = (n_s == v_s);
    assign Flags                = flags_q;

    // Evaluate the condition field against the held flags
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z_s;
            COND_NE: CondEx = ~z_s;
            COND_CS: CondEx = c_s;
            COND_CC: CondEx = ~c_s;
            COND_MI: CondEx = n_s;
            COND_PL: CondEx = ~n_s;
            COND_VS: CondEx = v_s;
            COND_VC: CondEx = ~v_s;
            COND_HI: CondEx = c_s & ~z_s;
            COND_LS: CondEx = ~c_s | z_s;
            COND_GE: CondEx = ge_s;
            COND_LT: CondEx = ~ge_s;
            COND_GT: CondEx = ~z_s & ge_s;
            COND_LE: CondEx = z_s | ~ge_s;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM control unit: instruction decode, Moore sequencing FSM and ALU decoder.
module multicycle_control
    import arm_mc_pkg::*;
#(
    parameter int   ALUCTRL_W = 3,
    parameter logic EN_BYTE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 ByteMem,
    output logic [3:0]           Flags,
    output logic                 Illegal
);

    statetype_t state_q, state_d;

    logic [3:0] dp_cmd_s;
    logic [2:0] dp_alu_s;
    logic       dp_legal_s;
    logic       instr_illegal_s;
    logic       cond_ex_s;
    logic       in_exec_s;
    logic [1:0] flag_write_s;
    logic       rd_is_pc_s;
    logic       pc_write_s, mem_write_s, reg_write_s, ir_write_s;
    logic       byte_state_s;
    logic [2:0] alu_code_s;

    assign dp_cmd_s   = Funct[4:1];
    assign rd_is_pc_s = (Rd == 4'd15);

    // ALU decoder: map the DP opcode to an ALU code and flag it legal or not
    always_comb begin
        dp_alu_s   = ALU_ADD;
        dp_legal_s = 1'b1;
        case (dp_cmd_s)
            DP_ADD:  dp_alu_s = ALU_ADD;
            DP_SUB:  dp_alu_s = ALU_SUB;
            DP_CMP:  dp_alu_s = ALU_SUB;
            DP_AND:  dp_alu_s = ALU_AND;
            DP_ORR:  dp_alu_s = ALU_ORR;
            DP_EOR: begin
                dp_alu_s   = ALU_EOR;
                dp_legal_s = (ALUCTRL_W >= 32'sd3);
            end
            DP_MOV: begin
                dp_alu_s   = ALU_MOV;
                dp_legal_s = (ALUCTRL_W >= 32'sd3);
            end
            default: dp_legal_s = 1'b0;
        endcase
    end

    assign instr_illegal_s = ((Op == OP_DP) & ~dp_legal_s) | (Op == 2'b11);

    // NZ follow any S-suffixed DP op; CV only follow the arithmetic ones
    assign in_exec_s       = (state_q == S_EXECR) | (state_q == S_EXECI);
    assign flag_write_s[1] = in_exec_s & Funct[0];
    assign flag_write_s[0] = in_exec_s & Funct[0] & dp_is_arith(dp_cmd_s);

    cond_logic u_cond_logic (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagWrite (flag_write_s),
        .Flags     (Flags),
        .CondEx    (cond_ex_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (instr_illegal_s | ~cond_ex_s) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = (dp_cmd_s == DP_CMP) ? S_FETCH : S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore datapath controls per state
    always_comb begin
        pc_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        alu_code_s   = ALU_ADD;
        byte_state_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB      = 2'b01;
                byte_state_s = 1'b1;
            end
            S_MEMRD: begin
                AdrSrc       = 1'b1;
                byte_state_s = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                byte_state_s = 1'b1;
                reg_write_s  = ~rd_is_pc_s;
                pc_write_s   = rd_is_pc_s;
            end
            S_MEMWR: begin
                AdrSrc       = 1'b1;
                mem_write_s  = 1'b1;
                byte_state_s = 1'b1;
            end
            S_EXECR: alu_code_s = dp_alu_s;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                alu_code_s = dp_alu_s;
            end
            S_ALUWB: begin
                reg_write_s = ~rd_is_pc_s;
                pc_write_s  = rd_is_pc_s;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_s = 1'b1;
            end
            default: alu_code_s = ALU_ADD;
        endcase
    end

    // Immediate and register-source selects depend only on the instruction class
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        case (Op)
            OP_MEM: begin
                ImmSrc = 2'b01;
                RegSrc = 2'b10;
            end
            OP_BR: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: begin
                ImmSrc = 2'b00;
                RegSrc = 2'b00;
            end
        endcase
    end

    // Write enables are held off while reset is asserted
    assign PCWrite    = pc_write_s & ~reset;
    assign MemWrite   = mem_write_s & ~reset;
    assign RegWrite   = reg_write_s & ~reset;
    assign IRWrite    = ir_write_s & ~reset;
    assign Illegal    = (state_q == S_DECODE) & instr_illegal_s & ~reset;
    assign ByteMem    = byte_state_s & EN_BYTE & Funct[2];
    assign ALUControl = alu_code_s[ALUCTRL_W-1:0];

endmodule
